// File: rtl/mem_controller.sv
// mem_controller: bridges CPU byte/half/word load-store requests onto a
// word-wide memory bus with big-endian lane steering, sign/zero extension
// of loads, misalignment detection and a bounded wait for the memory ack.

module mem_controller #(
   parameter int TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] MemAddr,
   input  logic [31:0] MemWData,
   output logic        Stall,
   output logic [31:0] MemRData,
   output logic        AddrError,
   output logic        BusError,
   output logic [31:0] DAddress,
   output logic [31:0] DWriteData,
   output logic        DWriteEnable,
   output logic        DReadEnable,
   output logic [3:0]  DByteEnable,
   input  logic        DAck,
   input  logic [31:0] DReadData
);

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;

   // The wait counter only has to reach TIMEOUT-1; keep at least 5 bits.
   localparam int CNT_W = ($clog2(TIMEOUT) > 5) ? $clog2(TIMEOUT) : 5;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      DONE
   } state_t;

   state_t           state;
   state_t           state_nxt;

   logic             req;
   logic             misaligned;
   logic             accept;
   logic             timeout_hit;
   logic [CNT_W-1:0] wait_cnt;

   logic             write_q;
   logic             signed_q;
   logic [1:0]       size_q;
   logic [1:0]       off_q;

   logic [3:0]       be_in;
   logic [31:0]      wd_in;
   logic [7:0]       lane8;
   logic [15:0]      lane16;
   logic [31:0]      load_ext;

   // A store wins when both request lines are high.
   assign req = MemRead | MemWrite;

   // Alignment check and lane steering for the request presented in IDLE
   always_comb begin
      // NOTE: every output of a combinational block gets a default first,
      // so no path through the case can leave it unassigned and infer a latch.
      misaligned = 1'b0;
      be_in      = 4'b1111;
      wd_in      = MemWData;
      case (MemSize)
         SZ_BYTE: begin
            be_in = 4'b1000 >> MemAddr[1:0];
            wd_in = {4{MemWData[7:0]}};
         end
         SZ_HALF: begin
            misaligned = MemAddr[0];
            be_in      = MemAddr[1] ? 4'b0011 : 4'b1100;
            wd_in      = {2{MemWData[15:0]}};
         end
         default: begin
            // Word, and the reserved size which behaves as a word.
            misaligned = (MemAddr[1:0] != 2'b00);
         end
      endcase
   end

   assign accept      = (state == IDLE) && req && !misaligned;
   assign timeout_hit = (state == WAIT) && !DAck && (wait_cnt == CNT_LAST);

   // State register
   always_ff @(posedge CLK) begin
      // NOTE: state is updated with non-blocking assignments so every
      // register samples the pre-edge values, whatever the block order.
      if (RST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and the combinational Stall / AddrError handshake
   always_comb begin
      state_nxt = state;
      Stall     = 1'b0;
      AddrError = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (misaligned) begin
                  AddrError = 1'b1;
               end else begin
                  Stall     = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            Stall     = 1'b1;
            state_nxt = WAIT;
         end
         WAIT: begin
            Stall = 1'b1;
            if (DAck || timeout_hit) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
      // Reset masks the handshake even while inputs are active.
      if (RST) begin
         Stall     = 1'b0;
         AddrError = 1'b0;
      end
   end

   // Lane extraction and sign/zero extension of the returned memory word
   always_comb begin
      lane8    = 8'h00;
      lane16   = off_q[1] ? DReadData[15:0] : DReadData[31:16];
      load_ext = DReadData;
      case (off_q)
         2'd0:    lane8 = DReadData[31:24];
         2'd1:    lane8 = DReadData[23:16];
         2'd2:    lane8 = DReadData[15:8];
         default: lane8 = DReadData[7:0];
      endcase
      case (size_q)
         SZ_BYTE: load_ext = {{24{signed_q & lane8[7]}}, lane8};
         SZ_HALF: load_ext = {{16{signed_q & lane16[15]}}, lane16};
         default: load_ext = DReadData;
      endcase
   end

   // Request capture, one-cycle bus strobes, wait counter and load result
   always_ff @(posedge CLK) begin
      if (RST) begin
         // NOTE: the bus-side and result registers are all cleared, since
         // their reset values are visible on the ports.
         write_q      <= 1'b0;
         signed_q     <= 1'b0;
         size_q       <= 2'b00;
         off_q        <= 2'b00;
         wait_cnt     <= '0;
         MemRData     <= '0;
         BusError     <= 1'b0;
         DAddress     <= '0;
         DWriteData   <= '0;
         DByteEnable  <= 4'b0000;
         DWriteEnable <= 1'b0;
         DReadEnable  <= 1'b0;
      end else begin
         DWriteEnable <= 1'b0;
         DReadEnable  <= 1'b0;
         BusError     <= 1'b0;

         if (accept) begin
            write_q      <= MemWrite;
            signed_q     <= MemSigned;
            size_q       <= MemSize;
            off_q        <= MemAddr[1:0];
            wait_cnt     <= '0;
            DAddress     <= {MemAddr[31:2], 2'b00};
            DByteEnable  <= be_in;
            DWriteData   <= wd_in;
            DWriteEnable <= MemWrite;
            DReadEnable  <= !MemWrite;
         end

         if (state == WAIT) begin
            if (DAck) begin
               if (!write_q) begin
                  MemRData <= load_ext;
               end
            end else if (timeout_hit) begin
               BusError <= 1'b1;
               MemRData <= '0;
            end else begin
               wait_cnt <= wait_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_mem_controller.sv
// tb_mem_controller: directed and randomized load/store traffic against a
// word-array memory slave, checked with a byte-level reference model.

module tb_mem_controller;

   localparam int TO = 8;

   logic        CLK;
   logic        RST;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MemSize;
   logic        MemSigned;
   logic [31:0] MemAddr;
   logic [31:0] MemWData;
   logic        Stall;
   logic [31:0] MemRData;
   logic        AddrError;
   logic        BusError;
   logic [31:0] DAddress;
   logic [31:0] DWriteData;
   logic        DWriteEnable;
   logic        DReadEnable;
   logic [3:0]  DByteEnable;
   logic        DAck;
   logic [31:0] DReadData;

   mem_controller #(.TIMEOUT(TO)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .MemRead      (MemRead),
      .MemWrite     (MemWrite),
      .MemSize      (MemSize),
      .MemSigned    (MemSigned),
      .MemAddr      (MemAddr),
      .MemWData     (MemWData),
      .Stall        (Stall),
      .MemRData     (MemRData),
      .AddrError    (AddrError),
      .BusError     (BusError),
      .DAddress     (DAddress),
      .DWriteData   (DWriteData),
      .DWriteEnable (DWriteEnable),
      .DReadEnable  (DReadEnable),
      .DByteEnable  (DByteEnable),
      .DAck         (DAck),
      .DReadData    (DReadData)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int n_cmp = 0;
   int n_bad = 0;

   // Slave memory (driven by the bus) and reference memory (spec rules).
   logic [31:0] smem [0:63];
   logic [31:0] rmem [0:63];
   logic [31:0] last_rdata;

   // Observations from the most recent access.
   int          stall_cnt;
   int          we_cnt;
   int          re_cnt;
   logic        o_aerr;
   logic        o_berr;
   logic        o_done;
   logic [31:0] o_rdata;
   logic [31:0] o_addr;
   logic [31:0] o_wd;
   logic [3:0]  o_be;
   logic        o_post_stall;
   logic        o_post_strobe;
   logic        o_post_berr;

   // ---------------- reference model ----------------
   function automatic logic ref_mis(input logic [1:0] sz, input logic [31:0] a);
      if (sz == 2'd0) return 1'b0;
      if (sz == 2'd1) return a[0];
      return a[1:0] != 2'b00;
   endfunction

   function automatic logic [3:0] ref_be(input logic [1:0] sz, input logic [1:0] off);
      if (sz == 2'd0) return 4'b1000 >> off;
      if (sz == 2'd1) return 4'b1100 >> off;
      return 4'b1111;
   endfunction

   function automatic logic [31:0] ref_wd(input logic [1:0] sz, input logic [31:0] wd);
      if (sz == 2'd0) return {4{wd[7:0]}};
      if (sz == 2'd1) return {2{wd[15:0]}};
      return wd;
   endfunction

   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                            input logic sg, input int k);
      logic [31:0] v;
      if (sz == 2'd0) begin
         v = (w >> (8 * (3 - k))) & 32'h0000_00FF;
         if (sg && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 2'd1) begin
         v = (w >> (8 * (2 - k))) & 32'h0000_FFFF;
         if (sg && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = w;
      end
      return v;
   endfunction

   // Byte address i of a word lives in bits [31-8i -: 8] (big-endian).
   task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
      int          k;
      logic [31:0] w;
      logic [7:0]  b;
      logic        hit;
      k = int'(a[1:0]);
      w = rmem[a[7:2]];
      for (int i = 0; i < 4; i++) begin
         if (sz == 2'd0) begin
            hit = (i == k);
            b   = wd[7:0];
         end else if (sz == 2'd1) begin
            hit = (i == k) || (i == k + 1);
            b   = (i == k) ? wd[15:8] : wd[7:0];
         end else begin
            hit = 1'b1;
            b   = 8'(wd >> (8 * (3 - i)));
         end
         if (hit) w = (w & ~(32'hFF << (8 * (3 - i)))) | ({24'd0, b} << (8 * (3 - i)));
      end
      rmem[a[7:2]] = w;
   endtask

   // ---------------- bus driver / memory slave ----------------
   // delay = cycles from strobe to DAck; negative means never acknowledge.
   task automatic access(input logic wr, input logic rd, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd, input int delay);
      int strobe_cyc;
      stall_cnt  = 0;
      we_cnt     = 0;
      re_cnt     = 0;
      o_aerr     = 1'b0;
      o_berr     = 1'b0;
      o_done     = 1'b0;
      o_rdata    = '0;
      o_addr     = '0;
      o_wd       = '0;
      o_be       = '0;
      strobe_cyc = -1;
      @(negedge CLK);
      MemWrite  = wr;
      MemRead   = rd;
      MemSize   = sz;
      MemSigned = sg;
      MemAddr   = addr;
      MemWData  = wd;
      for (int cyc = 0; cyc < 64 && !o_done; cyc++) begin
         if (cyc > 0) @(negedge CLK);
         #1;
         DAck      = 1'b0;
         DReadData = $urandom;
         if (Stall) stall_cnt++;
         if (cyc == 0) o_aerr = AddrError;
         if (DWriteEnable || DReadEnable) begin
            strobe_cyc = cyc;
            o_addr     = DAddress;
            o_be       = DByteEnable;
            o_wd       = DWriteData;
            if (DReadEnable) re_cnt++;
            if (DWriteEnable) begin
               we_cnt++;
               for (int i = 0; i < 4; i++)
                  if (DByteEnable[3-i])
                     smem[DAddress[7:2]][31-8*i -: 8] = DWriteData[31-8*i -: 8];
            end
         end
         if (!Stall) begin
            o_done   = 1'b1;
            o_berr   = BusError;
            o_rdata  = MemRData;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
         end
         if (strobe_cyc >= 0 && delay >= 0 && cyc == strobe_cyc + delay) begin
            DAck      = 1'b1;
            DReadData = smem[DAddress[7:2]];
         end
      end
      if (!o_done) begin
         n_cmp++;
         n_bad++;
         $display("FAIL access_bound: Stall still %b after 64 cycles, required 0", Stall);
         MemRead  = 1'b0;
         MemWrite = 1'b0;
      end
      @(negedge CLK);
      #1;
      DAck          = 1'b0;
      o_post_stall  = Stall;
      o_post_strobe = DWriteEnable | DReadEnable;
      o_post_berr   = BusError;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge CLK);
      MemRead = 1'b1; MemSize = 2'b10; MemAddr = 32'h6;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_mis: got %b, required 0", Stall); end
      n_cmp++; if (AddrError !== 1'b0) begin n_bad++; $display("FAIL rst_aerr: got %b, required 0", AddrError); end
      @(negedge CLK);
      MemAddr = 32'h40; MemWrite = 1'b1;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall_req: got %b, required 0", Stall); end
      n_cmp++; if (DWriteEnable !== 1'b0 || DReadEnable !== 1'b0) begin n_bad++; $display("FAIL rst_strobe: got we=%b re=%b, required 0", DWriteEnable, DReadEnable); end
      @(negedge CLK);
      MemRead = 1'b0; MemWrite = 1'b0;
      #1;
      n_cmp++; if (MemRData !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h, required 0", MemRData); end
      n_cmp++; if (BusError !== 1'b0) begin n_bad++; $display("FAIL rst_berr: got %b, required 0", BusError); end
      n_cmp++; if (DAddress !== 32'h0) begin n_bad++; $display("FAIL rst_daddr: got %h, required 0", DAddress); end
      n_cmp++; if (DWriteData !== 32'h0) begin n_bad++; $display("FAIL rst_dwdata: got %h, required 0", DWriteData); end
      n_cmp++; if (DByteEnable !== 4'h0) begin n_bad++; $display("FAIL rst_dbe: got %b, required 0000", DByteEnable); end
      RST = 1'b0;
      last_rdata = 32'h0;
   endtask

   task automatic test_store_byte();
      access(1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1);
      ref_store(32'h11, 2'b00, 32'hAB);
      n_cmp++; if (o_addr !== 32'h10) begin n_bad++; $display("FAIL sb_daddr: got %h, required 00000010", o_addr); end
      n_cmp++; if (o_be !== 4'b0100) begin n_bad++; $display("FAIL sb_dbe: got %b, required 0100", o_be); end
      n_cmp++; if (o_wd !== 32'hABAB_ABAB) begin n_bad++; $display("FAIL sb_dwdata: got %h, required abababab", o_wd); end
      n_cmp++; if (we_cnt !== 1 || re_cnt !== 0) begin n_bad++; $display("FAIL sb_strobes: got we=%0d re=%0d, required 1/0", we_cnt, re_cnt); end
      n_cmp++; if (stall_cnt !== 3) begin n_bad++; $display("FAIL sb_stall: got %0d cycles, required 3", stall_cnt); end
      n_cmp++; if (o_rdata !== last_rdata) begin n_bad++; $display("FAIL sb_rdata_kept: got %h, required %h", o_rdata, last_rdata); end
   endtask

   task automatic test_load_extend();
      logic [1:0]  szs  [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
      logic        sgs  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [31:0] adrs [4] = '{32'h22, 32'h22, 32'h20, 32'h22};
      logic [31:0] exps [4] = '{32'hFFFF_FFFF, 32'h0000_00FF, 32'hFFFF_8070, 32'h0000_FF01};
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h8070_FF01, 1);
      ref_store(32'h20, 2'b10, 32'h8070_FF01);
      for (int i = 0; i < 4; i++) begin
         access(1'b0, 1'b1, szs[i], sgs[i], adrs[i], 32'h0, 1);
         n_cmp++; if (o_rdata !== exps[i]) begin n_bad++; $display("FAIL load_ext_%0d: got %h, required %h", i, o_rdata, exps[i]); end
         n_cmp++; if (re_cnt !== 1 || we_cnt !== 0) begin n_bad++; $display("FAIL load_strobe_%0d: got re=%0d we=%0d, required 1/0", i, re_cnt, we_cnt); end
         last_rdata = exps[i];
      end
   endtask

   task automatic test_misaligned();
      logic [1:0]  szs  [4] = '{2'b10, 2'b01, 2'b01, 2'b11};
      logic        wrs  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] adrs [4] = '{32'h06, 32'h03, 32'h31, 32'h42};
      for (int i = 0; i < 4; i++) begin
         access(wrs[i], !wrs[i], szs[i], 1'b0, adrs[i], 32'hDEAD_BEEF, 1);
         n_cmp++; if (o_aerr !== 1'b1) begin n_bad++; $display("FAIL mis_aerr_%0d: got %b, required 1", i, o_aerr); end
         n_cmp++; if (stall_cnt !== 0) begin n_bad++; $display("FAIL mis_stall_%0d: got %0d cycles, required 0", i, stall_cnt); end
         n_cmp++; if (we_cnt + re_cnt !== 0 || o_post_strobe !== 1'b0) begin n_bad++; $display("FAIL mis_strobe_%0d: got %0d strobes, post=%b, required none", i, we_cnt + re_cnt, o_post_strobe); end
      end
   endtask

   task automatic test_both_high();
      logic [31:0] d;
      d = $urandom;
      access(1'b1, 1'b1, 2'b10, 1'b0, 32'h40, d, 1);
      ref_store(32'h40, 2'b10, d);
      n_cmp++; if (we_cnt !== 1 || re_cnt !== 0) begin n_bad++; $display("FAIL both_strobes: got we=%0d re=%0d, required 1/0", we_cnt, re_cnt); end
      n_cmp++; if (o_be !== 4'b1111) begin n_bad++; $display("FAIL both_dbe: got %b, required 1111", o_be); end
      n_cmp++; if (o_rdata !== last_rdata) begin n_bad++; $display("FAIL both_rdata_kept: got %h, required %h", o_rdata, last_rdata); end
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 1);
      n_cmp++; if (o_rdata !== d) begin n_bad++; $display("FAIL both_readback: got %h, required %h", o_rdata, d); end
      last_rdata = d;
   endtask

   task automatic test_timeout();
      int          delays [3] = '{-1, TO, TO + 1};
      logic        tmo;
      logic [31:0] exp_d;
      for (int i = 0; i < 3; i++) begin
         access(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, delays[i]);
         tmo   = (delays[i] < 0) || (delays[i] > TO);
         exp_d = tmo ? 32'h0 : rmem[8];
         n_cmp++; if (o_berr !== tmo) begin n_bad++; $display("FAIL tmo_berr_%0d: got %b, required %b", i, o_berr, tmo); end
         n_cmp++; if (o_rdata !== exp_d) begin n_bad++; $display("FAIL tmo_rdata_%0d: got %h, required %h", i, o_rdata, exp_d); end
         n_cmp++; if (stall_cnt !== TO + 2) begin n_bad++; $display("FAIL tmo_stall_%0d: got %0d cycles, required %0d", i, stall_cnt, TO + 2); end
         n_cmp++; if (o_post_berr !== 1'b0 || o_post_stall !== 1'b0 || o_post_strobe !== 1'b0) begin n_bad++; $display("FAIL tmo_after_%0d: got berr=%b stall=%b strobe=%b, required 0", i, o_post_berr, o_post_stall, o_post_strobe); end
         last_rdata = exp_d;
      end
   endtask

   task automatic test_reset_mid();
      int bad_cycles;
      access(1'b1, 1'b0, 2'b10, 1'b0, 32'h44, 32'h1234_5678, 1);
      ref_store(32'h44, 2'b10, 32'h1234_5678);
      access(1'b0, 1'b1, 2'b10, 1'b0, 32'h44, 32'h0, 1);
      n_cmp++; if (o_rdata !== 32'h1234_5678) begin n_bad++; $display("FAIL rmid_preload: got %h, required 12345678", o_rdata); end
      @(negedge CLK);
      MemRead = 1'b1; MemWrite = 1'b0; MemSize = 2'b10; MemAddr = 32'h44;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      n_cmp++; if (Stall !== 1'b1) begin n_bad++; $display("FAIL rmid_in_wait: got Stall=%b, required 1", Stall); end
      RST = 1'b1;
      MemRead = 1'b0;
      @(negedge CLK);
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rmid_stall_rst: got %b, required 0", Stall); end
      RST       = 1'b0;
      DAck      = 1'b1;
      DReadData = 32'hFFFF_FFFF;
      @(negedge CLK);
      #1;
      DAck = 1'b0;
      n_cmp++; if (Stall !== 1'b0) begin n_bad++; $display("FAIL rmid_stall: got %b, required 0", Stall); end
      n_cmp++; if (MemRData !== 32'h0) begin n_bad++; $display("FAIL rmid_rdata: got %h, required 0", MemRData); end
      n_cmp++; if (BusError !== 1'b0) begin n_bad++; $display("FAIL rmid_berr: got %b, required 0", BusError); end
      bad_cycles = 0;
      for (int i = 0; i < TO + 4; i++) begin
         @(negedge CLK);
         #1;
         if (BusError || Stall || DWriteEnable || DReadEnable) bad_cycles++;
      end
      n_cmp++; if (bad_cycles !== 0) begin n_bad++; $display("FAIL rmid_quiet: got %0d active cycles, required 0", bad_cycles); end
      last_rdata = 32'h0;
   endtask

   task automatic test_spurious_ack();
      @(negedge CLK);
      #1;
      DAck      = 1'b1;
      DReadData = $urandom;
      @(negedge CLK);
      #1;
      DAck = 1'b0;
      n_cmp++; if (Stall !== 1'b0 || DWriteEnable !== 1'b0 || DReadEnable !== 1'b0) begin n_bad++; $display("FAIL idle_ack_activity: got stall=%b we=%b re=%b, required 0", Stall, DWriteEnable, DReadEnable); end
      n_cmp++; if (MemRData !== last_rdata) begin n_bad++; $display("FAIL idle_ack_rdata: got %h, required %h", MemRData, last_rdata); end
   endtask

   task automatic test_random();
      int          op;
      int          delay;
      logic [1:0]  sz;
      logic        sg;
      logic        wr;
      logic        mis;
      logic        tmo;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] exp_d;
      for (int n = 0; n < 60; n++) begin
         op   = $urandom_range(0, 2);
         sz   = 2'($urandom_range(0, 3));
         sg   = 1'($urandom_range(0, 1));
         addr = 32'($urandom_range(0, 255));
         wd   = $urandom;
         if ($urandom_range(0, 3) != 0) begin
            if (sz == 2'b01) addr[0] = 1'b0;
            if (sz[1]) addr[1:0] = 2'b00;
         end
         delay = ($urandom_range(0, 9) == 0) ? -1 : $urandom_range(1, TO + 1);
         wr    = (op != 0);
         mis   = ref_mis(sz, addr);
         tmo   = (delay < 0) || (delay > TO);
         access(wr, op != 1, sz, sg, addr, wd, delay);
         n_cmp++; if (o_aerr !== mis) begin n_bad++; $display("FAIL rnd_aerr_%0d: got %b, required %b", n, o_aerr, mis); end
         if (mis) begin
            n_cmp++; if (stall_cnt !== 0 || we_cnt + re_cnt !== 0 || o_post_strobe !== 1'b0) begin n_bad++; $display("FAIL rnd_mis_quiet_%0d: got stall=%0d strobes=%0d, required 0", n, stall_cnt, we_cnt + re_cnt); end
         end else begin
            exp_d = tmo ? 32'h0 : (wr ? last_rdata : ref_load(rmem[addr[7:2]], sz, sg, int'(addr[1:0])));
            n_cmp++; if (stall_cnt !== (tmo ? TO + 2 : delay + 2)) begin n_bad++; $display("FAIL rnd_stall_%0d: got %0d, required %0d", n, stall_cnt, tmo ? TO + 2 : delay + 2); end
            n_cmp++; if (we_cnt !== int'(wr) || re_cnt !== int'(!wr)) begin n_bad++; $display("FAIL rnd_strobes_%0d: got we=%0d re=%0d, required %0d/%0d", n, we_cnt, re_cnt, wr, !wr); end
            n_cmp++; if (o_addr !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd_daddr_%0d: got %h, required %h", n, o_addr, {addr[31:2], 2'b00}); end
            n_cmp++; if (o_be !== ref_be(sz, addr[1:0])) begin n_bad++; $display("FAIL rnd_dbe_%0d: got %b, required %b", n, o_be, ref_be(sz, addr[1:0])); end
            if (wr) begin
               n_cmp++; if (o_wd !== ref_wd(sz, wd)) begin n_bad++; $display("FAIL rnd_dwdata_%0d: got %h, required %h", n, o_wd, ref_wd(sz, wd)); end
               ref_store(addr, sz, wd);
            end
            n_cmp++; if (o_berr !== tmo) begin n_bad++; $display("FAIL rnd_berr_%0d: got %b, required %b", n, o_berr, tmo); end
            n_cmp++; if (o_rdata !== exp_d) begin n_bad++; $display("FAIL rnd_rdata_%0d: got %h, required %h", n, o_rdata, exp_d); end
            n_cmp++; if (o_post_stall !== 1'b0 || o_post_berr !== 1'b0) begin n_bad++; $display("FAIL rnd_after_%0d: got stall=%b berr=%b, required 0", n, o_post_stall, o_post_berr); end
            last_rdata = exp_d;
         end
      end
   endtask

   initial begin
      RST       = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      MemSize   = 2'b00;
      MemSigned = 1'b0;
      MemAddr   = 32'h0;
      MemWData  = 32'h0;
      DAck      = 1'b0;
      DReadData = 32'h0;
      last_rdata = 32'h0;
      for (int i = 0; i < 64; i++) begin
         smem[i] = $urandom;
         rmem[i] = smem[i];
      end
      test_reset();
      test_store_byte();
      test_load_extend();
      test_misaligned();
      test_both_high();
      test_timeout();
      test_reset_mid();
      test_spurious_ack();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
